// File: rtl/vmem_fill.sv
// Rectangle fill engine: one command in, one framebuffer write per pixel out, row-major.
// Latency: accept -> SETUP (1 cycle) -> first write; done pulses the cycle after the last write transfer.
// Backpressure: wr_ready low holds the current write stable; cmd_ready is low whenever a command is in flight.
// Optional VMEM_FILL_CLIP_EN clips the rectangle to the 640x480 visible area; otherwise addresses wrap.
module vmem_fill (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [23:0] cmd_color,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [9:0]  wr_h_addr,
    output logic [8:0]  wr_v_addr,
    output logic [23:0] wr_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t      state;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [9:0]  w_q;
    logic [8:0]  h_q;
    logic [23:0] color_q;
    logic [9:0]  ew;
    logic [8:0]  eh;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [9:0]  ew_calc;
    logic [8:0]  eh_calc;

`ifdef VMEM_FILL_CLIP_EN
    localparam logic [9:0] H_RES = 10'd640;
    localparam logic [8:0] V_RES = 9'd480;

    logic [9:0] h_room;
    logic [8:0] v_room;

    always_comb begin
        h_room  = H_RES - x_q;
        v_room  = V_RES - y_q;
        ew_calc = w_q;
        eh_calc = h_q;
        if (x_q >= H_RES || y_q >= V_RES) begin
            ew_calc = '0;
            eh_calc = '0;
        end else begin
            if (h_room < w_q) ew_calc = h_room;
            if (v_room < h_q) eh_calc = v_room;
        end
    end
`else
    // Unclipped: the caller owns bounds; 10/9-bit sums wrap naturally.
    assign ew_calc = w_q;
    assign eh_calc = h_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_h_addr <= '0;
            wr_v_addr <= '0;
            wr_data   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            ew        <= '0;
            eh        <= '0;
            col       <= '0;
            row       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        x_q       <= cmd_x;
                        y_q       <= cmd_y;
                        w_q       <= cmd_w;
                        h_q       <= cmd_h;
                        color_q   <= cmd_color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    ew  <= ew_calc;
                    eh  <= eh_calc;
                    col <= '0;
                    row <= '0;
                    if (ew_calc == '0 || eh_calc == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wr_en     <= 1'b1;
                        wr_h_addr <= x_q;
                        wr_v_addr <= y_q;
                        wr_data   <= color_q;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (wr_ready) begin
                        if (col == ew - 10'd1) begin
                            col <= '0;
                            if (row == eh - 9'd1) begin
                                wr_en <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                row       <= row + 9'd1;
                                wr_h_addr <= x_q;
                                wr_v_addr <= y_q + row + 9'd1;
                            end
                        end else begin
                            col       <= col + 10'd1;
                            wr_h_addr <= x_q + col + 10'd1;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_fill.sv
// Directed bench for vmem_fill: reset state, row-major order, stalls, empty and edge rectangles, mid-fill reset.
module tb_vmem_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [9:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [23:0] cmd_color = '0;
    logic        wr_en;
    logic        wr_ready = 1'b1;
    logic [9:0]  wr_h_addr;
    logic [8:0]  wr_v_addr;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;

    vmem_fill dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_h_addr(wr_h_addr), .wr_v_addr(wr_v_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // wr_ready is owned by this process: held value or per-cycle toggle
    logic rdy_hold = 1'b1;
    logic tog = 1'b0;
    initial forever begin
        @(posedge clk);
        #2;
        wr_ready = tog ? ~wr_ready : rdy_hold;
    end

    // Transfer log and stall-hold monitor, sampled mid-cycle
    int xh[$];
    int xv[$];
    int xd[$];
    int xc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int en_cnt = 0;
    int stalls = 0;
    int hold_err = 0;
    initial begin
        logic       p_en;
        logic       p_rdy;
        logic [9:0] p_h;
        logic [8:0] p_v;
        p_en = 1'b0; p_rdy = 1'b1; p_h = '0; p_v = '0;
        forever begin
            @(negedge clk);
            if (p_en === 1'b1 && p_rdy === 1'b0) begin
                stalls++;
                if (!(wr_en === 1'b1 && wr_h_addr == p_h && wr_v_addr == p_v)) hold_err++;
            end
            if (wr_en === 1'b1) en_cnt++;
            if (wr_en === 1'b1 && wr_ready === 1'b1) begin
                xh.push_back(int'(wr_h_addr));
                xv.push_back(int'(wr_v_addr));
                xd.push_back(int'(wr_data));
                xc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            p_en = wr_en; p_rdy = wr_ready; p_h = wr_h_addr; p_v = wr_v_addr;
        end
    end

    int checks = 0;
    int errors = 0;
    int acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input int x, input int y, input int w, input int h, input int color);
        int n;
        bit ok;
        @(posedge clk);
        #2;
        cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = 24'(color);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                acc = cyc;
            end
        end
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int budget, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_xfer(input int idx, input int h, input int v, input int d);
        if (idx >= xh.size()) begin
            chk($sformatf("xfer%0d_missing", idx), 32'd0, 32'd1);
        end else begin
            chk($sformatf("xfer%0d_h", idx), 32'(xh[idx]), 32'(h));
            chk($sformatf("xfer%0d_v", idx), 32'(xv[idx]), 32'(v));
            chk($sformatf("xfer%0d_d", idx), 32'(xd[idx]), 32'(d));
        end
    endtask

    int base;
    int d0;
    int e0;
    int s0;
    int exp_h[6] = '{10, 11, 12, 10, 11, 12};
    int exp_v[6] = '{20, 20, 20, 21, 21, 21};

    initial begin
        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_h", 32'(wr_h_addr), 32'd0);
        chk("rst_v", 32'(wr_v_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // 3x2 red fill, always ready
        base = xh.size(); d0 = done_cnt;
        send_cmd(10, 20, 3, 2, 32'hFF0000);
        wait_done(50, d0);
        chk("basic_count", 32'(xh.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) chk_xfer(base + i, exp_h[i], exp_v[i], 32'hFF0000);
        if (xh.size() - base == 6) begin
            chk("basic_first_lat", 32'(xc[base] - acc), 32'd2);
            chk("basic_done_after_last", 32'(done_cyc - xc[base + 5]), 32'd1);
        end
        chk("basic_total_lat", 32'(done_cyc - acc), 32'd8);

        // Same command with wr_ready toggling
        base = xh.size(); d0 = done_cnt; s0 = stalls;
        tog = 1'b1;
        send_cmd(10, 20, 3, 2, 32'hFF0000);
        wait_done(100, d0);
        tog = 1'b0;
        repeat (2) @(negedge clk);
        chk("tog_count", 32'(xh.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) chk_xfer(base + i, exp_h[i], exp_v[i], 32'hFF0000);
        chk("tog_stalls_seen", 32'(stalls > s0), 32'd1);
        chk("tog_hold_err", 32'(hold_err), 32'd0);
        if (xh.size() - base == 6)
            chk("tog_done_after_last", 32'(done_cyc - xc[base + 5]), 32'd1);

        // Zero width: no writes, done two cycles after accept
        base = xh.size(); d0 = done_cnt; e0 = en_cnt;
        send_cmd(100, 100, 0, 5, 32'h123456);
        wait_done(20, d0);
        chk("w0_writes", 32'(en_cnt - e0), 32'd0);
        chk("w0_done_lat", 32'(done_cyc - acc), 32'd2);

`ifdef VMEM_FILL_CLIP_EN
        // Bottom-right corner clip
        base = xh.size(); d0 = done_cnt;
        send_cmd(638, 479, 5, 4, 32'h00FF00);
        wait_done(50, d0);
        chk("clip_count", 32'(xh.size() - base), 32'd2);
        chk_xfer(base, 638, 479, 32'h00FF00);
        chk_xfer(base + 1, 639, 479, 32'h00FF00);
        // Fully off-screen
        base = xh.size(); d0 = done_cnt; e0 = en_cnt;
        send_cmd(700, 10, 4, 4, 32'h0000FF);
        wait_done(20, d0);
        chk("offscreen_writes", 32'(en_cnt - e0), 32'd0);
`else
        // Horizontal wrap at column 1023
        base = xh.size(); d0 = done_cnt;
        send_cmd(1022, 511, 3, 1, 32'h0000FF);
        wait_done(50, d0);
        chk("wrap_count", 32'(xh.size() - base), 32'd3);
        chk_xfer(base, 1022, 511, 32'h0000FF);
        chk_xfer(base + 1, 1023, 511, 32'h0000FF);
        chk_xfer(base + 2, 0, 511, 32'h0000FF);
`endif

        // Reset during the third write of a 4x4 fill
        base = xh.size(); d0 = done_cnt;
        send_cmd(50, 60, 4, 4, 32'hABCDEF);
        for (int n = 0; n < 20 && xh.size() < base + 2; n++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_count", 32'(xh.size() - base), 32'd3);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // 1x1 after abort
        base = xh.size(); d0 = done_cnt;
        send_cmd(5, 6, 1, 1, 32'h777777);
        wait_done(20, d0);
        chk("post_count", 32'(xh.size() - base), 32'd1);
        chk_xfer(base, 5, 6, 32'h777777);
        chk("post_lat", 32'(done_cyc - acc), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmem_fill.md
# vmem_fill

Rectangle fill engine upstream of the video memory. Accepts one fill command at a time (origin, size, 24-bit RGB colour) over a valid/ready handshake. Emits one framebuffer write per pixel in row-major order on a write port with backpressure, feeding the vmem write side that the VGA scan-out reads from. Pixel addressing matches the scan-out: 10-bit horizontal and 9-bit vertical coordinates.

## Interface
- H_RES, 640, visible width in pixels; clip bound for x.
- V_RES, 480, visible height in pixels; clip bound for y.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  10  rectangle left column.
- cmd_y  in  9  rectangle top row.
- cmd_w  in  10  width in pixels; 0 is legal.
- cmd_h  in  9  height in pixels; 0 is legal.
- cmd_color  in  24  fill colour, {R[7:0],G[7:0],B[7:0]}.
- wr_en  out  1  write request valid.
- wr_ready  in  1  vmem accepts the write this cycle.
- wr_h_addr  out  10  pixel column.
- wr_v_addr  out  9  pixel row.
- wr_data  out  24  pixel colour.
- busy  out  1  command in progress (any state but IDLE).
- done  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, SETUP, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch x, y, w, h and colour, then go to SETUP.
- SETUP, one cycle:
  - Compute effective width ew and height eh (see Configuration).
  - If ew==0 or eh==0, go to DONE with no writes; otherwise go to FILL with col=0, row=0.
- FILL:
  - wr_en=1, wr_h_addr=x+col, wr_v_addr=y+row, wr_data=latched colour.
  - Outputs are held stable until wr_en&&wr_ready.
  - On a transfer, col increments.
  - At col==ew-1 the transfer sets col=0 and increments row.
  - At col==ew-1 and row==eh-1 the transfer goes to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- cmd_ready=0 in SETUP, FILL and DONE; commands are never queued.
- Internal counters are 10 bits (col) and 9 bits (row); address sums are computed one bit wider, then handled per Configuration.
- Reset:
  - State→IDLE.
  - cmd_ready=1, wr_en=0, busy=0, done=0.
  - wr_h_addr=0, wr_v_addr=0, wr_data=0.
- Reset mid-FILL aborts the command: no further writes and no done pulse.

## Timing
- Command accepted at edge N; SETUP occupies cycle N+1; first wr_en at cycle N+2.
- With wr_ready held high, one pixel is written per cycle; total time from accept to done pulse is ew*eh+2 cycles.
- done is asserted in the cycle after the last write transfer; cmd_ready returns high in the cycle after done.
- Earliest next accept is 1 cycle after done, so back-to-back commands have a 1-cycle IDLE gap.
- wr_ready low stalls the engine indefinitely; no write is dropped or duplicated.
- wr_ready is ignored when wr_en=0.

## Configuration
- Macro: VMEM_FILL_CLIP_EN.
- Defined:
  - If x>=H_RES or y>=V_RES, then ew=eh=0.
  - Otherwise ew=min(w, H_RES-x) and eh=min(h, V_RES-y).
  - No write is ever issued outside the visible area.
- Undefined:
  - ew=w and eh=h.
  - wr_h_addr=(x+col) mod 1024 and wr_v_addr=(y+row) mod 512; wrap-around addresses are emitted unchanged.
  - The caller must keep rectangles in bounds.

## Test plan
- Reset with rst=0 for 2 cycles → cmd_ready=1, wr_en=0, busy=0, done=0, all addresses and data 0.
- Command x=10,y=20,w=3,h=2,color=0xFF0000, wr_ready=1:
  - 6 writes, in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all with data 0xFF0000.
  - First write 2 cycles after accept; done 1 cycle after the last write.
- Same command with wr_ready toggling 1,0,1,0: each address is held while wr_ready=0, exactly 6 transfers occur, and done follows the 6th transfer.
- w=0 (any h) → no wr_en; done pulses 2 cycles after accept.
- With CLIP_EN, x=638,y=479,w=5,h=4 → exactly 2 writes, (638,479) and (639,479). With x=700 → no writes, done only.
- Reset asserted on the 3rd write of a 4x4 fill → wr_en=0 and no done pulse; a following 1x1 command completes normally.
